// File: rtl/demux4_reg_if.sv
// Producer/consumer bundle for demux4_reg: one input stream, four output lanes.
// slave modport is the demux side; master is the producer/consumer side.
interface demux4_reg_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_address;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic [7:0]       count0;
    logic [7:0]       count1;
    logic [7:0]       count2;
    logic [7:0]       count3;

    modport slave (
        input  in_valid, in_address, in_data, out_ready,
        output in_ready, out_valid, out0, out1, out2, out3,
        output count0, count1, count2, count3
    );

    modport master (
        output in_valid, in_address, in_data, out_ready,
        input  in_ready, out_valid, out0, out1, out2, out3,
        input  count0, count1, count2, count3
    );
endinterface

// File: rtl/demux4_reg.sv
// Registered 1-to-4 demultiplexer with a single-entry holding register per lane.
// Define DEMUX4_COUNT_EN to enable the per-lane 8-bit delivered-word counters.
module demux4_reg #(
    parameter int unsigned WIDTH = 32
) (
    input logic         clk,
    input logic         reset_n,
    demux4_reg_if.slave bus
);
    localparam logic EMPTY = 1'b0;
    localparam logic FULL  = 1'b1;

    logic [3:0]       valid_q;
    logic [3:0]       valid_d;
    logic [WIDTH-1:0] data_q [4];
    logic [3:0]       load;
    logic [3:0]       deliver;
    logic             in_ready;

    // Depends only on the addressed lane's state and its consumer.
    assign in_ready     = (valid_q[bus.in_address] == EMPTY) | bus.out_ready[bus.in_address];
    assign bus.in_ready = in_ready;

    always_comb begin
        load    = '0;
        deliver = valid_q & bus.out_ready;
        if (bus.in_valid && in_ready) begin
            load[bus.in_address] = 1'b1;
        end
        valid_d = valid_q;
        for (int k = 0; k < 4; k++) begin
            if (load[k]) begin
                valid_d[k] = FULL;
            end else if (deliver[k]) begin
                valid_d[k] = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    data_q[k] <= bus.in_data;
                end
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out0      = data_q[0];
    assign bus.out1      = data_q[1];
    assign bus.out2      = data_q[2];
    assign bus.out3      = data_q[3];

`ifdef DEMUX4_COUNT_EN
    logic [7:0] count_q [4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 4; k++) begin
                count_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (deliver[k]) begin
                    count_q[k] <= count_q[k] + 8'd1;
                end
            end
        end
    end

    assign bus.count0 = count_q[0];
    assign bus.count1 = count_q[1];
    assign bus.count2 = count_q[2];
    assign bus.count3 = count_q[3];
`else
    assign bus.count0 = 8'h00;
    assign bus.count1 = 8'h00;
    assign bus.count2 = 8'h00;
    assign bus.count3 = 8'h00;
`endif
endmodule
